// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for DIV/DIVU: {remainder, quotient} for HI/LO.
// Start/ready handshake, signed and unsigned modes, divide-by-zero fast path, cancel.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     dividend_i,
    input  logic [DATA_W-1:0]     divisor_i,
    input  logic                  cancel_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  rem;
    logic [DATA_W-1:0]  dvd;
    logic [DATA_W-1:0]  dsr;
    logic               neg_q;
    logic               neg_r;

    logic               dividend_neg;
    logic               divisor_neg;
    logic [DATA_W-1:0]  dividend_mag;
    logic [DATA_W-1:0]  divisor_mag;
    logic               divisor_zero;

    logic [DATA_W:0]    shifted;
    logic [DATA_W:0]    trial;
    logic               take;
    logic [DATA_W-1:0]  rem_step;
    logic [DATA_W-1:0]  dvd_step;
    logic [DATA_W-1:0]  q_fix;
    logic [DATA_W-1:0]  r_fix;
    logic               last;

    // Operand magnitudes; 0x80000000 maps onto itself, which the unsigned core handles.
    always_comb begin
        dividend_neg = signed_i & dividend_i[DATA_W-1];
        divisor_neg  = signed_i & divisor_i[DATA_W-1];
        dividend_mag = dividend_neg ? -dividend_i : dividend_i;
        divisor_mag  = divisor_neg  ? -divisor_i  : divisor_i;
        divisor_zero = (divisor_i == '0);
    end

    // One restoring step: bit DATA_W of the 33-bit difference is the borrow.
    always_comb begin
        shifted  = {rem, dvd[DATA_W-1]};
        trial    = shifted - {1'b0, dsr};
        take     = ~trial[DATA_W];
        rem_step = take ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
        dvd_step = {dvd[DATA_W-2:0], take};
        q_fix    = neg_q ? -dvd_step : dvd_step;
        r_fix    = neg_r ? -rem_step : rem_step;
        last     = (cnt == CNT_W'(DATA_W - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (cancel_i) begin
                    state_next = IDLE;
                end else if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        cnt   <= '0;
                        rem   <= '0;
                        dvd   <= dividend_mag;
                        dsr   <= divisor_mag;
                        neg_q <= dividend_neg ^ divisor_neg;
                        neg_r <= dividend_neg;
                        if (divisor_zero) begin
                            result_o <= {dividend_i, {DATA_W{1'b1}}};
                        end
                    end
                end
                CALC: begin
                    // Cancel beats the final iteration: result_o must not move.
                    if (cancel_i) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        rem <= rem_step;
                        dvd <= dvd_step;
                        if (last) begin
                            result_o <= {r_fix, q_fix};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready_o = (state == DONE);
    assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner
// sequences (cancel, mid-operation reset, held start) and random vs. arithmetic model.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        cancel_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .cancel_i   (cancel_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    // Reference: plain integer arithmetic, truncating division, remainder takes dividend sign.
    function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b, bit s);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat = 1 means ready seen in the cycle right after the start edge.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                           input bit hold, output logic [63:0] res,
                           output int lat, output int busy_cnt);
        start_i    = 1'b1;
        signed_i   = s;
        dividend_i = a;
        divisor_i  = b;
        tick();
        if (!hold) start_i = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        res      = 'x;
        for (int i = 1; i <= 60; i++) begin
            if (busy_o) busy_cnt++;
            if (ready_o && lat == 0) begin
                lat = i;
                res = result_o;
                start_i = 1'b0;
            end
            if (lat != 0 && !busy_o) break;
            tick();
        end
        start_i = 1'b0;
    endtask

    task automatic watch_no_ready(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (ready_o) seen++;
            tick();
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] prev;
        int          lat;
        int          bcnt;
        logic [31:0] a;
        logic [31:0] b;
        bit          s;

        vecs[0] = '{"udiv_100_7",    32'd100,        32'd7,          1'b0, {32'd2, 32'd14},                 33};
        vecs[1] = '{"sdiv_m7_2",     32'hFFFF_FFF9,  32'h0000_0002,  1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD},  33};
        vecs[2] = '{"sdiv_7_m2",     32'h0000_0007,  32'hFFFF_FFFE,  1'b1, {32'h0000_0001, 32'hFFFF_FFFD},  33};
        vecs[3] = '{"sdiv_ovf",      32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h0, 32'h8000_0000},          33};
        vecs[4] = '{"udiv_big",      32'h8000_0000,  32'hFFFF_FFFF,  1'b0, {32'h8000_0000, 32'h0},          33};
        vecs[5] = '{"div_zero",      32'h1234_5678,  32'h0,          1'b0, {32'h1234_5678, 32'hFFFF_FFFF},  1};
        vecs[6] = '{"udiv_max_1",    32'hFFFF_FFFF,  32'd1,          1'b0, {32'h0, 32'hFFFF_FFFF},          33};
        vecs[7] = '{"udiv_small",    32'd5,          32'd10,         1'b0, {32'd5, 32'd0},                  33};

        rst = 1'b1; start_i = 1'b1; signed_i = 1'b0; cancel_i = 1'b1;
        dividend_i = 32'd50; divisor_i = 32'd5;
        tick();
        tick();
        check("reset_result", result_o, 64'd0);
        check("reset_ready_busy", {62'd0, ready_o, busy_o}, 64'd0);
        rst = 1'b0; start_i = 1'b0; cancel_i = 1'b0;
        tick();

        // Directed table, issued back to back from the first IDLE cycle.
        for (int i = 0; i < 8; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, res, lat, bcnt);
            check({vecs[i].name, "_result"}, res, vecs[i].exp);
            check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
            check({vecs[i].name, "_busy_cycles"}, 64'(bcnt), 64'(vecs[i].lat));
        end

        // start_i held through CALC neither restarts nor stretches the operation.
        run_div(32'd1000, 32'd7, 1'b0, 1'b1, res, lat, bcnt);
        check("held_start_result", res, {32'd6, 32'd142});
        check("held_start_latency", 64'(lat), 64'd33);

        // Cancel sampled at iteration 10 of 1000/3.
        prev = result_o;
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
        tick();
        start_i = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        check("cancel_busy_before", 64'(busy_o), 64'd1);
        cancel_i = 1'b1;
        tick();
        cancel_i = 1'b0;
        check("cancel_busy_after", 64'(busy_o), 64'd0);
        check("cancel_result_kept", result_o, prev);
        watch_no_ready("cancel_no_ready", 40);
        check("cancel_result_still", result_o, prev);
        run_div(32'd9, 32'd3, 1'b0, 1'b0, res, lat, bcnt);
        check("after_cancel_result", res, {32'd0, 32'd3});
        check("after_cancel_latency", 64'(lat), 64'd33);

        // Cancel coinciding with the final iteration.
        prev = result_o;
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd77; divisor_i = 32'd4;
        tick();
        start_i = 1'b0;
        for (int i = 1; i < 32; i++) tick();
        cancel_i = 1'b1;
        tick();
        cancel_i = 1'b0;
        check("cancel_last_state", {62'd0, ready_o, busy_o}, 64'd0);
        check("cancel_last_result", result_o, prev);

        // Reset at iteration 20.
        start_i = 1'b1; signed_i = 1'b1; dividend_i = 32'hFFFF_0000; divisor_i = 32'd789;
        tick();
        start_i = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_result", result_o, 64'd0);
        check("midrst_ready_busy", {62'd0, ready_o, busy_o}, 64'd0);
        watch_no_ready("midrst_no_ready", 40);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = b >> $urandom_range(1, 31);
                default: begin end
            endcase
            run_div(a, b, s, 1'b0, res, lat, bcnt);
            check($sformatf("rand%0d_result", i), res, ref_div(a, b, s));
            check($sformatf("rand%0d_latency", i), 64'(lat), (b == 32'd0) ? 64'd1 : 64'd33);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
